memory_access: RTL and testbench

//  MEM pipeline stage; consumes the EX/MEM registers and drives the data-memory bus.

---
 rtl/memory_access.sv | 182 ++++++++++++++++++
 tb/tb_memory_access.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// memory_access: MEM pipeline stage. Drives the data-memory bus through a
// req/gnt/rvalid handshake, stalls the pipeline while an access is in flight,
// aligns store data, extends load data and registers the MEM/WB stage.
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When defined, misaligned
// accesses are trapped. When undefined, they are forced to natural alignment.

package memory_access_pkg;
  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_oper_t;
endpackage

module memory_access
  import memory_access_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] alu_oper2_i,
  input  mem_oper_t   mem_oper_i,
  input  logic        trap_i,
  input  logic        wb_use_mem_i,
  input  logic        write_rd_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] alu_result_o,
  output logic [31:0] mem_data_o,
  output logic        wb_use_mem_o,
  output logic        write_rd_o,
  output logic [4:0]  rd_addr_o,
  output logic        trap_o
);

  // IDLE: no access in flight; REQ: request waiting for gnt;
  // WAIT: granted, waiting for rvalid; DONE: response held while stall_i
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;

  logic        is_load, is_store, is_half, is_word;
  logic        misaligned, valid;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata_buf, load_word, load_ext, nxt_mem_data;
  logic [15:0] lane;
  logic        wb_load;

  // Operation decode, alignment handling and access-valid qualification
  always_comb begin
    is_load  = mem_oper_i inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    is_store = mem_oper_i inside {MEM_SB, MEM_SH, MEM_SW};
    is_half  = mem_oper_i inside {MEM_LH, MEM_LHU, MEM_SH};
    is_word  = mem_oper_i inside {MEM_LW, MEM_SW};
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned = (is_half & alu_result_i[0]) |
                 (is_word & (alu_result_i[1:0] != 2'b00));
    off        = alu_result_i[1:0];
`else
    misaligned = 1'b0;
    off        = alu_result_i[1:0];
    if (is_half) off[0] = 1'b0;
    if (is_word) off = 2'b00;
`endif
    valid = (is_load | is_store) & ~trap_i & ~misaligned;
  end

  // Byte-enable and lane-replicated store data; loads use the same enables
  always_comb begin
    case (mem_oper_i)
      MEM_LB, MEM_LBU, MEM_SB: be = 4'b0001 << off;
      MEM_LH, MEM_LHU, MEM_SH: be = 4'b0011 << off;
      MEM_LW, MEM_SW:          be = 4'hF;
      default:                 be = 4'h0;
    endcase
    if (mem_oper_i == MEM_SB)      wdata = {4{alu_oper2_i[7:0]}};
    else if (mem_oper_i == MEM_SH) wdata = {2{alu_oper2_i[15:0]}};
    else                           wdata = alu_oper2_i;
  end

  // The pipeline is frozen by stall_o while pending, so the EX/MEM inputs
  // (and hence addr/be/we/wdata) stay stable until gnt.
  assign dmem_addr_o  = {alu_result_i[31:2], 2'b00};
  assign dmem_be_o    = be;
  assign dmem_we_o    = is_store;
  assign dmem_wdata_o = wdata;
  assign dmem_req_o   = ~rst_i & (((state == IDLE) & valid) | (state == REQ));
  assign stall_o      = ~rst_i & (((state == IDLE) & valid) | (state == REQ) |
                                  ((state == WAIT) & ~dmem_rvalid_i));

  // Bus handshake sequencer; one outstanding transaction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (valid) state <= dmem_gnt_i ? WAIT : REQ;
        REQ:  if (dmem_gnt_i) state <= WAIT;
        WAIT: if (dmem_rvalid_i) state <= stall_i ? DONE : IDLE;
        DONE: if (!stall_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Keep the response word so a stalled MEM/WB can take it when DONE exits
  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_buf <= 32'h0;
    else if ((state == WAIT) && dmem_rvalid_i) rdata_buf <= dmem_rdata_i;
  end

  // Load lane selection and sign/zero extension; non-loads yield zero
  always_comb begin
    load_word = (state == DONE) ? rdata_buf : dmem_rdata_i;
    lane      = 16'(load_word >> {off, 3'b000});
    case (mem_oper_i)
      MEM_LB:  load_ext = {{24{lane[7]}}, lane[7:0]};
      MEM_LBU: load_ext = {24'h0, lane[7:0]};
      MEM_LH:  load_ext = {{16{lane[15]}}, lane};
      MEM_LHU: load_ext = {16'h0, lane};
      MEM_LW:  load_ext = load_word;
      default: load_ext = 32'h0;
    endcase
  end

  // While an access is pending the MEM/WB stage is fed a bubble, so the
  // instruction reaches writeback exactly once, with its final data.
  always_comb begin
    wb_load      = 1'b0;
    nxt_mem_data = 32'h0;
    case (state)
      IDLE: wb_load = ~valid;
      WAIT: begin
        wb_load      = dmem_rvalid_i;
        nxt_mem_data = load_ext;
      end
      DONE: begin
        wb_load      = 1'b1;
        nxt_mem_data = load_ext;
      end
      default: wb_load = 1'b0;
    endcase
  end

  // MEM/WB register: flush clears, stall holds, otherwise result or bubble
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      alu_result_o <= 32'h0;
      mem_data_o   <= 32'h0;
      wb_use_mem_o <= 1'b0;
      write_rd_o   <= 1'b0;
      rd_addr_o    <= 5'h0;
      trap_o       <= 1'b0;
    end else if (!stall_i) begin
      if (wb_load) begin
        alu_result_o <= alu_result_i;
        mem_data_o   <= nxt_mem_data;
        wb_use_mem_o <= wb_use_mem_i;
        write_rd_o   <= write_rd_i & ~misaligned;
        rd_addr_o    <= rd_addr_i;
        trap_o       <= trap_i | misaligned;
      end else begin
        alu_result_o <= 32'h0;
        mem_data_o   <= 32'h0;
        wb_use_mem_o <= 1'b0;
        write_rd_o   <= 1'b0;
        rd_addr_o    <= 5'h0;
        trap_o       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Testbench for memory_access: acts as the EX/MEM stage and the bus slave,
// scoreboards expected MEM/WB contents. Honours MEM_MISALIGN_TRAP_EN.
module tb_memory_access;
  import memory_access_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, trap, wb_use_mem, write_rd, stall_in, flush;
  logic [31:0] alu_result, alu_oper2;
  mem_oper_t   mem_oper;
  logic [4:0]  rd_addr;
  logic        stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] alu_result_q, mem_data_q;
  logic        wb_use_mem_q, write_rd_q, trap_q;
  logic [4:0]  rd_addr_q;

  memory_access dut (
    .clk_i(clk), .rst_i(rst), .alu_result_i(alu_result), .alu_oper2_i(alu_oper2),
    .mem_oper_i(mem_oper), .trap_i(trap), .wb_use_mem_i(wb_use_mem),
    .write_rd_i(write_rd), .rd_addr_i(rd_addr), .stall_i(stall_in), .flush_i(flush),
    .stall_o(stall), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_be_o(dmem_be),
    .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_gnt_i(dmem_gnt),
    .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .alu_result_o(alu_result_q), .mem_data_o(mem_data_q), .wb_use_mem_o(wb_use_mem_q),
    .write_rd_o(write_rd_q), .rd_addr_o(rd_addr_q), .trap_o(trap_q)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mem;
    logic        use_mem;
    logic        wr;
    logic [4:0]  rd;
    logic        trp;
  } wb_t;

  wb_t exp_q[$];
  wb_t last_exp;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    wb_t e;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check({tag, "_alu"}, alu_result_q, e.alu);
      check({tag, "_mem"}, mem_data_q, e.mem);
      check({tag, "_use"}, 32'(wb_use_mem_q), 32'(e.use_mem));
      check({tag, "_wr"},  32'(write_rd_q), 32'(e.wr));
      check({tag, "_rd"},  32'(rd_addr_q), 32'(e.rd));
      check({tag, "_trap"}, 32'(trap_q), 32'(e.trp));
    end
  endtask

  function automatic logic [3:0] m_be(input mem_oper_t op, input logic [1:0] off);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 4'(1 << off);
      MEM_LH, MEM_LHU, MEM_SH: return off[1] ? 4'b1100 : 4'b0011;
      default:                 return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input mem_oper_t op, input logic [31:0] d);
    if (op == MEM_SB) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (op == MEM_SH) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_ext(input mem_oper_t op, input logic [1:0] off,
                                        input logic [31:0] w);
    logic [31:0] s;
    s = w >> (int'(off) * 8);
    case (op)
      MEM_LB:  return {{24{s[7]}}, s[7:0]};
      MEM_LBU: return {24'h0, s[7:0]};
      MEM_LH:  return {{16{s[15]}}, s[15:0]};
      MEM_LHU: return {16'h0, s[15:0]};
      MEM_LW:  return w;
      default: return 32'h0;
    endcase
  endfunction

  // Entered and left just after a falling edge.
  task automatic access(input mem_oper_t op, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rword, input logic [31:0] exp_mem,
                        input int gnt_dly, input int rv_dly, input int hold);
    logic ld, st;
    logic [4:0] rd;
    int stall_cnt;
    wb_t e;
    ld = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    st = op inside {MEM_SB, MEM_SH, MEM_SW};
    rd = 5'($urandom_range(1, 31));
    stall_cnt = 0;
    mem_oper = op; alu_result = a; alu_oper2 = d; trap = 1'b0;
    wb_use_mem = ld; write_rd = ld; rd_addr = rd;
    e = '{alu: a, mem: exp_mem, use_mem: ld, wr: ld, rd: rd, trp: 1'b0};
    exp_q.push_back(e);
    #1;
    for (int c = 0; c <= gnt_dly; c++) begin
      check("req", 32'(dmem_req), 32'd1);
      check("addr", dmem_addr, {a[31:2], 2'b00});
      check("be", 32'(dmem_be), 32'(m_be(op, a[1:0])));
      check("we", 32'(dmem_we), 32'(st));
      if (st) check("wdata", dmem_wdata, m_wdata(op, d));
      stall_cnt += int'(stall);
      if (c == gnt_dly) dmem_gnt = 1'b1;
      @(negedge clk); dmem_gnt = 1'b0; #1;
    end
    for (int c = 0; c <= rv_dly; c++) begin
      check("req_wait", 32'(dmem_req), 32'd0);
      if (c == 0) check("bubble_wr", 32'(write_rd_q), 32'd0);
      if (c == rv_dly) begin
        dmem_rvalid = 1'b1; dmem_rdata = rword; stall_in = (hold > 0);
        #1;
        check("stall_rv", 32'(stall), 32'd0);
      end else begin
        stall_cnt += int'(stall);
      end
      @(negedge clk); dmem_rvalid = 1'b0; dmem_rdata = $urandom; #1;
    end
    check("stall_cycles", 32'(stall_cnt), 32'(gnt_dly + 1 + rv_dly));
    for (int c = 0; c < hold; c++) begin
      check("done_req", 32'(dmem_req), 32'd0);
      check("done_stall", 32'(stall), 32'd0);
      check("done_hold_wr", 32'(write_rd_q), 32'd0);
      check("done_hold_alu", alu_result_q, 32'd0);
      if (c == hold - 1) stall_in = 1'b0;
      @(negedge clk); #1;
    end
    pop_check("acc");
    mem_oper = MEM_NOP; write_rd = 1'b0; wb_use_mem = 1'b0;
  endtask

  task automatic alu_op(input mem_oper_t op, input logic [31:0] a, input logic trp);
    logic [4:0] rd;
    wb_t e;
    rd = 5'($urandom_range(1, 31));
    mem_oper = op; alu_result = a; trap = trp; write_rd = 1'b1; wb_use_mem = 1'b0;
    rd_addr = rd;
    e = '{alu: a, mem: 32'h0, use_mem: 1'b0, wr: 1'b1, rd: rd, trp: trp};
    exp_q.push_back(e);
    #1;
    check("nop_req", 32'(dmem_req), 32'd0);
    check("nop_stall", 32'(stall), 32'd0);
    @(negedge clk); #1;
    pop_check("alu");
    mem_oper = MEM_NOP; trap = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_oper = MEM_SW; alu_result = 32'h100; alu_oper2 = 32'h0;
    trap = 1'b0; wb_use_mem = 1'b0; write_rd = 1'b0; rd_addr = 5'd0;
    stall_in = 1'b0; flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_alu", alu_result_q, 32'd0);
    check("rst_wr", 32'(write_rd_q), 32'd0);
    check("rst_trap", 32'(trap_q), 32'd0);
    mem_oper = MEM_NOP; rst = 1'b0;
    @(negedge clk); #1;

    // Directed accesses: op, addr, data, rdata, expected load result, gnt/rvalid delay, hold
    access(MEM_SW,  32'h100, 32'hDEADBEEF, 32'h0,        32'h0,        0, 1, 0);
    access(MEM_SB,  32'h103, 32'h000000A5, 32'h0,        32'h0,        0, 0, 0);
    access(MEM_LB,  32'h102, 32'h0,        32'h0080FF00, 32'hFFFFFF80, 0, 0, 0);
    access(MEM_LBU, 32'h102, 32'h0,        32'h0080FF00, 32'h00000080, 0, 0, 0);
    access(MEM_LH,  32'h102, 32'h0,        32'h80010000, 32'hFFFF8001, 0, 0, 0);
    access(MEM_LHU, 32'h102, 32'h0,        32'h80010000, 32'h00008001, 1, 0, 0);
    access(MEM_SH,  32'h202, 32'h00001234, 32'h0,        32'h0,        0, 0, 0);
    access(MEM_LW,  32'h204, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 3, 0, 0);
    access(MEM_LB,  32'h301, 32'h0,        32'h00007F00, 32'h0000007F, 0, 1, 3);

    // Non-memory op and trapped memory op pass straight through
    alu_op(MEM_NOP, 32'h0000ABCD, 1'b0);
    alu_op(MEM_LW,  32'h00000400, 1'b1);

    // stall_i holds MEM/WB
    alu_op(MEM_NOP, 32'h11110000, 1'b0);
    stall_in = 1'b1; alu_result = 32'h22220000; write_rd = 1'b1; rd_addr = 5'd9;
    exp_q.push_back('{alu: 32'h22220000, mem: 32'h0, use_mem: 1'b0, wr: 1'b1, rd: 5'd9, trp: 1'b0});
    @(negedge clk); #1;
    check("stall_hold_alu", alu_result_q, last_exp.alu);
    check("stall_hold_rd", 32'(rd_addr_q), 32'(last_exp.rd));
    stall_in = 1'b0;
    @(negedge clk); #1;
    pop_check("stall_release");

    // flush_i clears MEM/WB
    alu_op(MEM_NOP, 32'h33330000, 1'b0);
    flush = 1'b1; alu_result = 32'h44440000; write_rd = 1'b1;
    @(negedge clk); #1;
    check("flush_alu", alu_result_q, 32'd0);
    check("flush_wr", 32'(write_rd_q), 32'd0);
    check("flush_rd", 32'(rd_addr_q), 32'd0);
    flush = 1'b0; write_rd = 1'b0;

`ifdef MEM_MISALIGN_TRAP_EN
    for (int i = 0; i < 2; i++) begin
      mem_oper = (i == 0) ? MEM_LW : MEM_SH;
      alu_result = (i == 0) ? 32'h102 : 32'h201;
      trap = 1'b0; write_rd = 1'b1; wb_use_mem = 1'b0; rd_addr = 5'd7;
      #1;
      check("mis_req", 32'(dmem_req), 32'd0);
      check("mis_stall", 32'(stall), 32'd0);
      @(negedge clk); #1;
      check("mis_trap", 32'(trap_q), 32'd1);
      check("mis_wr", 32'(write_rd_q), 32'd0);
      check("mis_alu", alu_result_q, alu_result);
    end
    mem_oper = MEM_NOP; write_rd = 1'b0;
`else
    access(MEM_LW, 32'h102, 32'h0, 32'h12345678, 32'h12345678, 0, 0, 0);
    access(MEM_LH, 32'h103, 32'h0, 32'hBEEF0000, 32'hFFFFBEEF, 0, 0, 0);
`endif

    // Random aligned accesses with random handshake timing
    for (int i = 0; i < 10; i++) begin
      mem_oper_t op;
      logic [31:0] a, w;
      op = mem_oper_t'($urandom_range(1, 8));
      a  = $urandom;
      if (op inside {MEM_LH, MEM_LHU, MEM_SH}) a[0] = 1'b0;
      if (op inside {MEM_LW, MEM_SW}) a[1:0] = 2'b00;
      w = $urandom;
      access(op, a, $urandom, w, m_ext(op, a[1:0], w),
             $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset while a request is waiting for gnt; MEM/WB held non-zero by stall_i
    alu_op(MEM_NOP, 32'h55550000, 1'b0);
    stall_in = 1'b1; mem_oper = MEM_LW; alu_result = 32'h500; write_rd = 1'b1;
    wb_use_mem = 1'b1;
    @(negedge clk); #1;
    check("req_state_req", 32'(dmem_req), 32'd1);
    check("req_state_hold", alu_result_q, 32'h55550000);
    rst = 1'b1;
    #1;
    check("rst_req_now", 32'(dmem_req), 32'd0);
    @(negedge clk); #1;
    check("rst_req_next", 32'(dmem_req), 32'd0);
    check("rst_stall_next", 32'(stall), 32'd0);
    check("rst_alu_next", alu_result_q, 32'd0);
    check("rst_wr_next", 32'(write_rd_q), 32'd0);
    mem_oper = MEM_NOP; write_rd = 1'b0; wb_use_mem = 1'b0; stall_in = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
    access(MEM_LBU, 32'h601, 32'h0, 32'h0000C300, 32'h000000C3, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
